// File: rtl/alu_serial_seq.sv
// Bit-serial operand sequencer and result collector for a 1-bit ALU.
// Feeds operands LSB first, chains carry, and assembles the WIDTH-bit result.
module alu_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             alu_op_a,
  output logic             alu_op_b,
  output logic             alu_cin,
  output logic [3:0]       alu_opcode,
  input  logic             alu_result,
  input  logic             alu_cout
);

  localparam logic [3:0] OP_ADDC = 4'h1;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      result_q <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      result_q <= result_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    result_d = result_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          op_d    = opcode;
          cnt_d   = '0;
          carry_d = (opcode == OP_ADDC) ? cin : 1'b0;
        end
      end
      S_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = {alu_result, res_sh_q[WIDTH-1:1]};
        carry_d  = alu_cout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d  = S_DONE;
          result_d = {alu_result, res_sh_q[WIDTH-1:1]};
          cout_d   = alu_cout;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The ALU sees zeros whenever no operation is in flight.
  always_comb begin
    alu_op_a   = 1'b0;
    alu_op_b   = 1'b0;
    alu_cin    = 1'b0;
    alu_opcode = '0;
    if (state_q == S_RUN) begin
      alu_op_a   = a_sh_q[0];
      alu_op_b   = b_sh_q[0];
      alu_cin    = carry_q;
      alu_opcode = op_q;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Testbench for alu_serial_seq with a behavioural 1-bit ALU.
// Directed vectors, corner sequences and random ops vs a word-level model.
module tb_alu_serial_seq;

  localparam int W = 8;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDC = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   opcode;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         alu_op_a, alu_op_b, alu_cin;
  logic [3:0]   alu_opcode;
  logic         alu_result, alu_cout;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] prev_res;

  always #5 clk = ~clk;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_cin(alu_cin),
    .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_cout(alu_cout)
  );

  // 1-bit ALU: logic ops report cout=0
  always_comb begin
    alu_result = 1'b0;
    alu_cout   = 1'b0;
    case (alu_opcode)
      OP_ADD, OP_ADDC: begin
        alu_result = alu_op_a ^ alu_op_b ^ alu_cin;
        alu_cout   = (alu_op_a & alu_op_b) | (alu_cin & (alu_op_a ^ alu_op_b));
      end
      OP_AND: alu_result = alu_op_a & alu_op_b;
      OP_OR:  alu_result = alu_op_a | alu_op_b;
      OP_XOR: alu_result = alu_op_a ^ alu_op_b;
      default: ;
    endcase
  end

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic         ci;
    logic [W-1:0] er;
    logic         ec;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] av,
                              input logic [W-1:0] bv, input logic ci,
                              input logic [W-1:0] er, input logic ec);
    vec_t v;
    v.op = op; v.av = av; v.bv = bv; v.ci = ci; v.er = er; v.ec = ec;
    return v;
  endfunction

  function automatic logic [W:0] model(input logic [3:0] op,
                                       input logic [W-1:0] av,
                                       input logic [W-1:0] bv,
                                       input logic ci);
    int unsigned s;
    case (op)
      OP_ADD:  s = int'(av) + int'(bv);
      OP_ADDC: s = int'(av) + int'(bv) + int'(ci);
      OP_AND:  s = int'(av & bv);
      OP_OR:   s = int'(av | bv);
      OP_XOR:  s = int'(av ^ bv);
      default: s = 0;
    endcase
    return (W+1)'(s);
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic ci,
                        output logic [W-1:0] r, output logic c);
    int n;
    bit seen;
    @(negedge clk);
    opcode = op; a = av; b = bv; cin = ci; start = 1'b1;
    n = 0;
    seen = 0;
    while (!seen && n < 30) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        start = 1'b0;
        opcode = 4'($urandom_range(0, 4));
        b = W'($urandom);
        cin = ~ci;
      end
      if (n == 2) begin
        start = 1'b1;
        a = 8'h11;
      end
      if (n == 3) start = 1'b0;
      if (n == 4) begin
        chk("busy_in_run", 32'(busy), 32'd1);
        chk("result_held", 32'(result), 32'(prev_res));
        chk("alu_opcode_run", 32'(alu_opcode), 32'(op));
      end
      if (done) seen = 1;
    end
    chk("latency", 32'(n), 32'(W + 1));
    chk("busy_at_done", 32'(busy), 32'd1);
    r = result;
    c = carry_out;
    @(posedge clk);
    #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_not_busy", 32'(busy), 32'd0);
    chk("idle_alu_drive", 32'({alu_op_a, alu_op_b, alu_cin, alu_opcode}),
        32'd0);
    prev_res = r;
  endtask

  initial begin
    logic [W-1:0] r;
    logic         c;
    logic [W:0]   m;
    int           pulses;
    logic [3:0]   rop;
    logic [W-1:0] ra, rb;
    logic         rc;

    vecs[0] = mk(OP_ADD,  8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
    vecs[1] = mk(OP_ADD,  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    vecs[2] = mk(OP_ADDC, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
    vecs[3] = mk(OP_ADD,  8'h00, 8'h00, 1'b1, 8'h00, 1'b0);
    vecs[4] = mk(OP_XOR,  8'hF0, 8'hAA, 1'b0, 8'h5A, 1'b0);
    vecs[5] = mk(OP_AND,  8'hF0, 8'hAA, 1'b0, 8'hA0, 1'b0);
    vecs[6] = mk(OP_OR,   8'hF0, 8'hAA, 1'b0, 8'hFA, 1'b0);
    vecs[7] = mk(OP_ADDC, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
    vecs[8] = mk(OP_ADD,  8'h80, 8'h80, 1'b0, 8'h00, 1'b1);

    rst = 1'b1; start = 1'b0; opcode = '0; a = '0; b = '0; cin = 1'b0;
    prev_res = '0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_carry", 32'(carry_out), 32'd0);
    chk("rst_alu", 32'({alu_op_a, alu_op_b, alu_cin, alu_opcode}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].op, vecs[i].av, vecs[i].bv, vecs[i].ci, r, c);
      chk($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].er));
      chk($sformatf("vec%0d_carry", i), 32'(c), 32'(vecs[i].ec));
    end

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 4));
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      m = model(rop, ra, rb, rc);
      run_op(rop, ra, rb, rc, r, c);
      chk($sformatf("rnd%0d_result", i), 32'(r), 32'(m[W-1:0]));
      chk($sformatf("rnd%0d_carry", i), 32'(c), 32'(m[W]));
    end

    // Abort: reset part-way through a run.
    @(negedge clk);
    opcode = OP_ADD; a = 8'hFF; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_carry", 32'(carry_out), 32'd0);
    chk("abort_alu", 32'({alu_op_a, alu_op_b, alu_cin, alu_opcode}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);

    prev_res = '0;
    run_op(OP_ADD, 8'h5A, 8'h33, 1'b0, r, c);
    chk("recover_result", 32'(r), 32'h8D);
    chk("recover_carry", 32'(c), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
